arf_multiport: RTL and testbench

//  Parametrised, clocked architectural register file, the successor to the single-cycle ARF.

---
 rtl/arf_multiport.sv | 113 +++++++++++
 tb/tb_arf_multiport.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/arf_multiport.sv
// arf_multiport: parametrised architectural register file with registered,
// write-forwarding reads and a post-reset clearing sweep.
//  clk, rst     : clock and synchronous active-high reset
//  ready        : 1 once the sweep has finished (RUN); reads/writes accepted
//  rd_en/rd_addr: per-port read request; rd_data/rd_valid return one cycle later
//  wr_en/wr_addr/wr_data: per-port retire writes, highest-index port wins
module arf_multiport #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned AR_SIZE  = 7,
  parameter int unsigned AR_ARRAY = 128,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 3,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*AR_SIZE-1:0]  rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_valid,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*AR_SIZE-1:0]  wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data
);

  localparam logic [AR_SIZE-1:0] LAST_IDX = AR_SIZE'(AR_ARRAY - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state;
  logic [AR_SIZE-1:0]      sweep_ptr;
  logic [DATA_W-1:0]       mem [AR_ARRAY];
  logic [NUM_WR-1:0]       wr_ok;
  logic [NUM_RD*DATA_W-1:0] rd_next;

  // An address is backed by storage: in range and not the hardwired zero reg.
  function automatic logic addr_live(input logic [AR_SIZE-1:0] a);
    return (32'(a) < AR_ARRAY) && !(ZERO_REG && (a == '0));
  endfunction

  // Writes that actually land this cycle (only in RUN, dropped addresses removed).
  always_comb begin
    wr_ok = '0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      wr_ok[j] = wr_en[j] && (state == ST_RUN) && addr_live(wr_addr[j*AR_SIZE +: AR_SIZE]);
    end
  end

  // Read value per port: storage, overridden by same-cycle writes in ascending
  // port order so the highest-index matching writer wins.
  always_comb begin
    rd_next = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (addr_live(rd_addr[i*AR_SIZE +: AR_SIZE])) begin
        rd_next[i*DATA_W +: DATA_W] = mem[rd_addr[i*AR_SIZE +: AR_SIZE]];
      end
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j] && (wr_addr[j*AR_SIZE +: AR_SIZE] == rd_addr[i*AR_SIZE +: AR_SIZE])) begin
          rd_next[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Storage: no reset so it can map to RAM; the sweep clears it instead.
  // Later loop iterations override earlier ones, giving highest-index priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[sweep_ptr] <= '0;
      end else begin
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if (wr_ok[j]) begin
            mem[wr_addr[j*AR_SIZE +: AR_SIZE]] <= wr_data[j*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Sweep FSM and registered read outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      sweep_ptr <= '0;
      ready     <= 1'b0;
      rd_valid  <= '0;
      rd_data   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          sweep_ptr <= sweep_ptr + AR_SIZE'(1);
          if (sweep_ptr == LAST_IDX) begin
            sweep_ptr <= '0;
            state     <= ST_RUN;
            ready     <= 1'b1;
          end
        end
        ST_RUN:  ready <= 1'b1;
        default: state <= ST_INIT;
      endcase

      rd_valid <= rd_en & {NUM_RD{ready}};
      for (int unsigned i = 0; i < NUM_RD; i++) begin
        if (rd_en[i] && ready) begin
          rd_data[i*DATA_W +: DATA_W] <= rd_next[i*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_arf_multiport.sv
// Directed bench for arf_multiport: one instance with ZERO_REG=1 and one with
// ZERO_REG=0 share all inputs.
module tb_arf_multiport;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en;
  logic [13:0] rd_addr;
  logic [2:0]  wr_en;
  logic [20:0] wr_addr;
  logic [95:0] wr_data;

  logic        ready,    ready_nz;
  logic [63:0] rd_data,  rd_data_nz;
  logic [1:0]  rd_valid, rd_valid_nz;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arf_multiport dut (
    .clk(clk), .rst(rst), .ready(ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  arf_multiport #(.ZERO_REG(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .ready(ready_nz),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_nz), .rd_valid(rd_valid_nz),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [1:0] en, input logic [6:0] a0, input logic [6:0] a1);
    rd_en   = en;
    rd_addr = {a1, a0};
  endtask

  task automatic set_wr(input logic [2:0] en,
                        input logic [6:0] a0, input logic [31:0] d0,
                        input logic [6:0] a1, input logic [31:0] d1,
                        input logic [6:0] a2, input logic [31:0] d2);
    wr_en   = en;
    wr_addr = {a2, a1, a0};
    wr_data = {d2, d1, d0};
  endtask

  // Releases reset and walks the 128-cycle sweep, checking ready timing.
  task automatic sweep(input string tag);
    int early = 0;
    rst = 1'b0;
    for (int k = 1; k < 128; k++) begin
      step();
      if (ready !== 1'b0 || ready_nz !== 1'b0 || rd_valid !== 2'b00) early++;
    end
    chk({tag, "_not_ready_during_sweep"}, 64'(early), 64'd0);
    step();
    chk({tag, "_ready_at_128"}, {62'd0, ready_nz, ready}, 64'h3);
  endtask

  initial begin
    rst = 1'b1;
    set_rd(2'b00, 7'd0, 7'd0);
    set_wr(3'b000, 7'd0, 32'h0, 7'd0, 32'h0, 7'd0, 32'h0);
    step();
    chk("reset_ready",    64'(ready),    64'd0);
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_rd_data",  rd_data,       64'd0);

    // INIT: reads and writes must be ignored (writes persist to the last INIT edge).
    set_rd(2'b11, 7'd3, 7'd7);
    set_wr(3'b111, 7'd7, 32'h7777, 7'd100, 32'h1000, 7'd120, 32'h1200);
    sweep("init");
    chk("init_rd_data_held", rd_data, 64'd0);
    chk("init_rd_valid_at_ready", 64'(rd_valid), 64'd0);
    set_wr(3'b000, 7'd0, 32'h0, 7'd0, 32'h0, 7'd0, 32'h0);

    // Every address reads 0 after the sweep, on both instances.
    begin
      int bad = 0;
      for (int a = 0; a < 128; a++) begin
        set_rd(2'b11, 7'(a), 7'(127 - a));
        step();
        if (rd_valid !== 2'b11 || rd_data !== 64'd0 || rd_data_nz !== 64'd0) bad++;
      end
      chk("sweep_all_zero", 64'(bad), 64'd0);
    end

    // Basic write then read.
    set_rd(2'b00, 7'd0, 7'd0);
    set_wr(3'b001, 7'd5, 32'hDEADBEEF, 7'd0, 32'h0, 7'd0, 32'h0);
    step();
    chk("idle_rd_valid", 64'(rd_valid), 64'd0);
    set_wr(3'b000, 7'd0, 32'h0, 7'd0, 32'h0, 7'd0, 32'h0);
    set_rd(2'b11, 7'd5, 7'd5);
    step();
    chk("wr_rd_data",  rd_data,       64'hDEADBEEF_DEADBEEF);
    chk("wr_rd_valid", 64'(rd_valid), 64'h3);

    // Three-way conflict with same-cycle forwarding, then from storage.
    set_wr(3'b111, 7'd9, 32'h1, 7'd9, 32'h2, 7'd9, 32'h3);
    set_rd(2'b11, 7'd9, 7'd9);
    step();
    chk("conflict_fwd", rd_data, 64'h00000003_00000003);
    set_wr(3'b000, 7'd0, 32'h0, 7'd0, 32'h0, 7'd0, 32'h0);
    step();
    chk("conflict_stored", rd_data, 64'h00000003_00000003);

    // Partial conflict: port1 beats port0 on addr10; port2 alone on addr11.
    set_wr(3'b111, 7'd10, 32'hA, 7'd10, 32'hB, 7'd11, 32'hC);
    set_rd(2'b11, 7'd10, 7'd11);
    step();
    chk("mid_prio_fwd", rd_data, 64'h0000000C_0000000B);
    set_wr(3'b000, 7'd0, 32'h0, 7'd0, 32'h0, 7'd0, 32'h0);
    set_rd(2'b11, 7'd11, 7'd10);
    step();
    chk("mid_prio_stored", rd_data, 64'h0000000B_0000000C);

    // Zero register: dropped with ZERO_REG=1, stored with ZERO_REG=0.
    set_wr(3'b100, 7'd0, 32'h0, 7'd0, 32'h0, 7'd0, 32'hFFFF);
    set_rd(2'b11, 7'd0, 7'd0);
    step();
    chk("zero_fwd",    rd_data,    64'd0);
    chk("nz_zero_fwd", rd_data_nz, 64'h0000FFFF_0000FFFF);
    set_wr(3'b000, 7'd0, 32'h0, 7'd0, 32'h0, 7'd0, 32'h0);
    step();
    chk("zero_stored",    rd_data,    64'd0);
    chk("nz_zero_stored", rd_data_nz, 64'h0000FFFF_0000FFFF);

    // Only port 0 reads: port 1 data holds, rd_valid only on port 0.
    set_rd(2'b11, 7'd9, 7'd5);
    step();
    chk("pre_hold_data", rd_data, 64'hDEADBEEF_00000003);
    set_rd(2'b01, 7'd10, 7'd9);
    step();
    chk("partial_rd_data",  rd_data,       64'hDEADBEEF_0000000B);
    chk("partial_rd_valid", 64'(rd_valid), 64'h1);

    // Hold: rd_en low for 3 cycles while addresses move and a write lands.
    set_rd(2'b00, 7'd9, 7'd9);
    set_wr(3'b001, 7'd9, 32'h55, 7'd0, 32'h0, 7'd0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("hold_rd_data",  rd_data,       64'hDEADBEEF_0000000B);
      chk("hold_rd_valid", 64'(rd_valid), 64'd0);
      set_wr(3'b000, 7'd0, 32'h0, 7'd0, 32'h0, 7'd0, 32'h0);
    end
    set_rd(2'b10, 7'd0, 7'd9);
    step();
    chk("after_hold_read", rd_data, 64'h00000055_0000000B);

    // Reset mid-operation with a read in flight.
    rst = 1'b1;
    set_rd(2'b11, 7'd5, 7'd5);
    step();
    chk("midrst_rd_valid", 64'(rd_valid), 64'd0);
    chk("midrst_ready",    64'(ready),    64'd0);
    chk("midrst_rd_data",  rd_data,       64'd0);
    set_rd(2'b00, 7'd5, 7'd0);
    sweep("resweep");
    set_rd(2'b11, 7'd5, 7'd0);
    step();
    chk("resweep_addr5",    rd_data,    64'd0);
    chk("resweep_nz_addr0", rd_data_nz, 64'd0);
    chk("resweep_rd_valid", 64'(rd_valid), 64'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
